gf2m_digit_mul: RTL and testbench



---
 rtl/gf2m_digit_mul_pkg.sv | 23 ++
 rtl/gf2m_mulx_step.sv | 16 +
 rtl/gf2m_digit_mul.sv | 98 +++++++++
 tb/tb_gf2m_digit_mul.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_digit_mul_pkg.sv
// Shared definitions for the digit-serial GF(2^m) multiplier: operation codes,
// controller states, default sizing and the digit-count helper.
package gf2m_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MAC = 2'b01;
  localparam logic [1:0] OP_SQR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_M = 144;
  localparam int DEFAULT_D = 1;

  function automatic int num_digits(input int m, input int d);
    return (m + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_mulx_step.sv
// One Horner step: multiply the accumulator by x modulo f, then add a when the
// multiplier bit is set.
module gf2m_mulx_step #(
  parameter int M = 144
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic [M-1:0] mod,
  input  logic         b_bit,
  output logic [M-1:0] acc_out
);

  // The bit shifted out of the top stands for x^M, which reduces to mod.
  assign acc_out = {acc[M-2:0], 1'b0} ^ ({M{acc[M-1]}} & mod) ^ ({M{b_bit}} & a);

endmodule

// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^M) multiplier (MUL / MAC / SQR); consumes D multiplier bits
// per cycle, most significant digit first.
module gf2m_digit_mul
  import gf2m_pkg::*;
#(
  parameter int M = DEFAULT_M,
  parameter int D = DEFAULT_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op_mode,
  input  logic [M-1:0] multiplicand,
  input  logic [M-1:0] multiplier,
  input  logic [M-1:0] mod,
  output logic [M-1:0] mul_out,
  output logic         busy,
  output logic         done
);

  localparam int N  = num_digits(M, D);
  localparam int NB = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t        state_reg;
  logic [M-1:0]  acc_reg;
  logic [M-1:0]  a_reg;
  logic [M-1:0]  mod_reg;
  logic [M-1:0]  mul_out_reg;
  logic [NB-1:0] b_reg;
  logic          mac_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [M-1:0]  chain [D+1];

  assign chain[0] = acc_reg;

  // The top D bits of b_reg form the current digit; the chain walks it high to low.
  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_step
      gf2m_mulx_step #(.M(M)) u_step (
        .acc    (chain[gi]),
        .a      (a_reg),
        .mod    (mod_reg),
        .b_bit  (b_reg[NB-1-gi]),
        .acc_out(chain[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      acc_reg     <= '0;
      a_reg       <= '0;
      mod_reg     <= '0;
      mul_out_reg <= '0;
      b_reg       <= '0;
      mac_reg     <= 1'b0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == ST_RUN) begin
        acc_reg <= chain[D];
        b_reg   <= b_reg << D;
        if (cnt_reg == '0) begin
          state_reg   <= ST_DONE;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b1;
          mul_out_reg <= chain[D] ^ (mac_reg ? mul_out_reg : '0);
        end else begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end else if (start) begin
        // Zero-extension of b puts any padding zeros in the first digit.
        state_reg <= ST_RUN;
        busy_reg  <= 1'b1;
        acc_reg   <= '0;
        a_reg     <= multiplicand;
        mod_reg   <= mod;
        b_reg     <= NB'((op_mode == OP_SQR) ? multiplicand : multiplier);
        mac_reg   <= (op_mode == OP_MAC);
        cnt_reg   <= CW'(N - 1);
      end else begin
        state_reg <= ST_IDLE;
      end
    end
  end

  assign mul_out = mul_out_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_gf2m_digit_mul.sv
// Self-checking bench: three multiplier instances (M=8/D=1, M=8/D=3, M=144/D=8)
// compared against an LSB-first shift-and-add GF(2^m) reference model.
module tb_gf2m_digit_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         start_s [3];
  logic [1:0]   op_s    [3];
  logic [143:0] a_s     [3];
  logic [143:0] b_s     [3];
  logic [143:0] f_s     [3];
  logic [143:0] out_s   [3];
  logic         busy_s  [3];
  logic         done_s  [3];
  logic [7:0]   out0, out1;
  logic [143:0] out2;

  int msz [3] = '{8, 8, 144};
  int ndg [3] = '{8, 3, 18};
  logic [143:0] prev_exp [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gf2m_digit_mul #(.M(8), .D(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .op_mode(op_s[0]),
    .multiplicand(a_s[0][7:0]), .multiplier(b_s[0][7:0]), .mod(f_s[0][7:0]),
    .mul_out(out0), .busy(busy_s[0]), .done(done_s[0]));

  gf2m_digit_mul #(.M(8), .D(3)) u_d3 (
    .clk(clk), .rst(rst), .start(start_s[1]), .op_mode(op_s[1]),
    .multiplicand(a_s[1][7:0]), .multiplier(b_s[1][7:0]), .mod(f_s[1][7:0]),
    .mul_out(out1), .busy(busy_s[1]), .done(done_s[1]));

  gf2m_digit_mul #(.M(144), .D(8)) u_big (
    .clk(clk), .rst(rst), .start(start_s[2]), .op_mode(op_s[2]),
    .multiplicand(a_s[2]), .multiplier(b_s[2]), .mod(f_s[2]),
    .mul_out(out2), .busy(busy_s[2]), .done(done_s[2]));

  assign out_s[0] = {136'd0, out0};
  assign out_s[1] = {136'd0, out1};
  assign out_s[2] = out2;

  function automatic logic [143:0] rand144();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[143:0];
  endfunction

  // Reference: schoolbook LSB-first, a doubled (times x, reduced) per bit of b.
  function automatic logic [143:0] ref_mul(input int m, input logic [143:0] a,
                                           input logic [143:0] b, input logic [143:0] f);
    logic [143:0] r, aa, mask;
    logic c;
    mask = (m == 144) ? {144{1'b1}} : ((144'd1 << m) - 144'd1);
    aa = a & mask;
    r = '0;
    for (int i = 0; i < m; i++) begin
      if (b[i]) r ^= aa;
      c = aa[m-1];
      aa = (aa << 1) & mask;
      if (c) aa ^= (f & mask);
    end
    return r;
  endfunction

  function automatic logic [143:0] ref_op(input int k, input logic [1:0] op, input logic [143:0] a,
                                          input logic [143:0] b, input logic [143:0] f);
    if (op == 2'b10) return ref_mul(msz[k], a, a, f);
    if (op == 2'b01) return ref_mul(msz[k], a, b, f) ^ prev_exp[k];
    return ref_mul(msz[k], a, b, f);
  endfunction

  // Issues one operation from the current cycle and waits (bounded) for done.
  task automatic run_op(input int k, input logic [1:0] op, input logic [143:0] a,
                        input logic [143:0] b, input logic [143:0] f,
                        output logic [143:0] res, output int cyc, output bit busy_ok);
    op_s[k] = op; a_s[k] = a; b_s[k] = b; f_s[k] = f; start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    a_s[k] = rand144(); b_s[k] = rand144(); f_s[k] = rand144(); op_s[k] = 2'($urandom);
    cyc = 1;
    busy_ok = 1'b1;
    while (!done_s[k] && cyc < 100) begin
      if (!busy_s[k]) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (busy_s[k]) busy_ok = 1'b0;
    res = out_s[k];
    $display("txn inst=%0d op=%0d a=%h b=%h f=%h out=%h cycles=%0d", k, op, a, b, f, res, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      prev_exp[k] = '0;
      n_checks += 3;
      if (out_s[k] !== 144'd0) begin n_fail++; $display("FAIL reset_out inst=%0d got=%h exp=0", k, out_s[k]); end
      if (busy_s[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy inst=%0d got=%b exp=0", k, busy_s[k]); end
      if (done_s[k] !== 1'b0) begin n_fail++; $display("FAIL reset_done inst=%0d got=%b exp=0", k, done_s[k]); end
    end
  endtask

  task automatic test_mul_d1();
    logic [143:0] r; int c; bit bok;
    run_op(0, 2'b00, 144'h57, 144'h83, 144'h1B, r, c, bok);
    prev_exp[0] = 144'hC1;
    n_checks += 3;
    if (r !== 144'hC1) begin n_fail++; $display("FAIL mul_d1_result got=%h exp=c1", r); end
    if (c != 9) begin n_fail++; $display("FAIL mul_d1_done_cycle got=%0d exp=9", c); end
    if (!bok) begin n_fail++; $display("FAIL mul_d1_busy got=bad exp=high cycles 1..8"); end
  endtask

  task automatic test_mul_d3();
    logic [143:0] r; int c; bit bok;
    run_op(1, 2'b00, 144'h57, 144'h13, 144'h1B, r, c, bok);
    prev_exp[1] = 144'hFE;
    n_checks += 3;
    if (r !== 144'hFE) begin n_fail++; $display("FAIL mul_d3_result got=%h exp=fe", r); end
    if (c != 4) begin n_fail++; $display("FAIL mul_d3_done_cycle got=%0d exp=4", c); end
    if (!bok) begin n_fail++; $display("FAIL mul_d3_busy got=bad exp=high cycles 1..3"); end
  endtask

  task automatic test_sqr_mac();
    logic [143:0] r; int c; bit bok;
    run_op(0, 2'b10, 144'h80, 144'hFF, 144'h1B, r, c, bok);
    n_checks++;
    if (r !== 144'h9A) begin n_fail++; $display("FAIL sqr_result got=%h exp=9a", r); end
    run_op(0, 2'b00, 144'h57, 144'h83, 144'h1B, r, c, bok);
    n_checks++;
    if (r !== 144'hC1) begin n_fail++; $display("FAIL mul_before_mac got=%h exp=c1", r); end
    run_op(0, 2'b01, 144'h57, 144'h13, 144'h1B, r, c, bok);
    prev_exp[0] = 144'h3F;
    n_checks++;
    if (r !== 144'h3F) begin n_fail++; $display("FAIL mac_result got=%h exp=3f", r); end
  endtask

  task automatic test_handshake();
    int cyc, ndone, first;
    logic [143:0] r, rfirst; int c; bit bok;
    @(posedge clk); #1;
    op_s[0] = 2'b00; a_s[0] = 144'h57; b_s[0] = 144'h83; f_s[0] = 144'h1B; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    ndone = 0; first = 0; rfirst = '0;
    for (cyc = 1; cyc <= 12; cyc++) begin
      if (cyc == 4) begin
        start_s[0] = 1'b1; a_s[0] = 144'hFF; b_s[0] = 144'hFF; op_s[0] = 2'b10;
      end else begin
        start_s[0] = 1'b0;
      end
      if (done_s[0]) begin
        ndone++;
        if (first == 0) begin first = cyc; rfirst = out_s[0]; end
      end
      @(posedge clk); #1;
    end
    start_s[0] = 1'b0;
    prev_exp[0] = 144'hC1;
    n_checks += 3;
    if (ndone != 1) begin n_fail++; $display("FAIL busy_start_done_count got=%0d exp=1", ndone); end
    if (first != 9) begin n_fail++; $display("FAIL busy_start_done_cycle got=%0d exp=9", first); end
    if (rfirst !== 144'hC1) begin n_fail++; $display("FAIL busy_start_result got=%h exp=c1", rfirst); end
    run_op(0, 2'b00, 144'h02, 144'h03, 144'h1B, r, c, bok);
    prev_exp[0] = 144'h06;
    run_op(0, 2'b00, 144'h57, 144'h13, 144'h1B, r, c, bok);
    prev_exp[0] = 144'hFE;
    n_checks += 3;
    if (c != 9) begin n_fail++; $display("FAIL back_to_back_cycle got=%0d exp=9", c); end
    if (r !== 144'hFE) begin n_fail++; $display("FAIL back_to_back_result got=%h exp=fe", r); end
    if (!bok) begin n_fail++; $display("FAIL back_to_back_busy got=bad exp=high cycles 1..8"); end
  endtask

  task automatic test_reset_abort();
    int cyc, ndone;
    logic [143:0] r; int c; bit bok;
    @(posedge clk); #1;
    op_s[0] = 2'b00; a_s[0] = 144'h57; b_s[0] = 144'h83; f_s[0] = 144'h1B; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    for (cyc = 1; cyc < 5; cyc++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) prev_exp[k] = '0;
    n_checks += 3;
    if (busy_s[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy_s[0]); end
    if (done_s[0] !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done_s[0]); end
    if (out_s[0] !== 144'd0) begin n_fail++; $display("FAIL abort_out got=%h exp=0", out_s[0]); end
    ndone = 0;
    for (cyc = 0; cyc < 12; cyc++) begin
      if (done_s[0]) ndone++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    rst = 1'b1; start_s[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_s[0] = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy_s[0] !== 1'b0) begin n_fail++; $display("FAIL start_with_rst got=%b exp=0", busy_s[0]); end
    run_op(0, 2'b00, 144'h57, 144'h83, 144'h1B, r, c, bok);
    prev_exp[0] = 144'hC1;
    n_checks++;
    if (r !== 144'hC1) begin n_fail++; $display("FAIL after_abort_result got=%h exp=c1", r); end
  endtask

  task automatic test_random_small();
    logic [143:0] a, b, f, r, e; logic [1:0] op; int c; bit bok;
    for (int i = 0; i < 60; i++) begin
      int k;
      k = i % 2;
      op = 2'($urandom);
      a = 144'($urandom_range(0, 255));
      b = 144'($urandom_range(0, 255));
      f = ($urandom_range(0, 7) == 0) ? 144'd0 : 144'($urandom_range(0, 255));
      e = ref_op(k, op, a, b, f);
      run_op(k, op, a, b, f, r, c, bok);
      prev_exp[k] = e;
      n_checks += 2;
      if (r !== e) begin n_fail++; $display("FAIL rand_small_result inst=%0d got=%h exp=%h", k, r, e); end
      if (c != ndg[k] + 1) begin n_fail++; $display("FAIL rand_small_cycle inst=%0d got=%0d exp=%0d", k, c, ndg[k] + 1); end
    end
  endtask

  task automatic test_big();
    logic [143:0] a, b, f, r, e; logic [1:0] op; int c; bit bok;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom);
      a = rand144(); b = rand144(); f = rand144();
      e = ref_op(2, op, a, b, f);
      run_op(2, op, a, b, f, r, c, bok);
      prev_exp[2] = e;
      n_checks += 2;
      if (r !== e) begin n_fail++; $display("FAIL big_result i=%0d got=%h exp=%h", i, r, e); end
      if (c != 19) begin n_fail++; $display("FAIL big_done_cycle i=%0d got=%0d exp=19", i, c); end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; op_s[k] = 2'b00; a_s[k] = '0; b_s[k] = '0; f_s[k] = '0; prev_exp[k] = '0;
    end
    test_reset();
    test_mul_d1();
    test_mul_d3();
    test_sqr_mac();
    test_handshake();
    test_reset_abort();
    test_random_small();
    test_big();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
